multicore_nonce_ctrl: RTL and testbench
=======================================

Name: multicore_nonce_ctrl

Overview:
- Parametrised control unit for the miner top.
- Distributes disjoint nonce streams to NUM_CORES double-SHA256 pipelines and registers new work into them.
- Checks every core's final hash word against the golden value and suppresses results produced during pipeline warm-up.
- Queues golden nonces in a FIFO with a valid/ready handshake towards the comm block, and stops cleanly on nonce-space exhaustion.

Parameters:
NUM_CORES, 4, number of hasher pipelines; power of 2, 1..16
PIPE_LATENCY, 253, cycles from a nonce being driven to its hash2 word being presented back
FIFO_DEPTH, 8, golden-nonce FIFO entries; power of 2, >=2
GOLDEN_WORD, 32'hA41F32E7, hash2 value that marks a golden ticket

Ports:
hash_clk  in  1  hashing clock, sole clock
reset  in  1  synchronous, active-high
new_work  in  1  single-cycle pulse: midstate_in/data_in valid, restart search
midstate_in  in  256  work midstate
data_in  in  96  work data tail
midstate_out  out  256  registered midstate to all cores
data_out  out  96  registered data to all cores
core_nonce  out  32*NUM_CORES  nonce for core k in bits [32k+31:32k]
core_hash2  in  32*NUM_CORES  hash2 word from core k in bits [32k+31:32k]
golden_valid  out  1  FIFO non-empty
golden_nonce  out  32  FIFO head
golden_ready  in  1  pop FIFO head when golden_valid & golden_ready
busy  out  1  high in HASH and DRAIN
exhausted  out  1  high in DONE
overflow  out  1  sticky: golden nonce dropped

Behaviour:
- Reset values: state IDLE, base=0, all core_nonce=0, midstate_out=0, data_out=0, FIFO empty, golden_valid=0, golden_nonce=0, busy=0, exhausted=0, overflow=0, pending flags clear.
- midstate_out/data_out load from the inputs on the new_work edge only. They hold otherwise.
- Nonce generation: core_nonce[k] = base + k, registered. base advances by NUM_CORES every HASH cycle. All arithmetic is mod 2^32.
- States:
  - IDLE --new_work--> HASH.
  - HASH --(base == 2^32-NUM_CORES, final group driven)--> DRAIN.
  - DRAIN --(PIPE_LATENCY+1 cycles elapsed)--> DONE.
  - DONE --new_work--> HASH.
  - new_work in any state --> HASH with base=0, warm-up restarted, pending flags cleared, overflow cleared. FIFO contents are retained.
- In DRAIN and DONE: base holds and core_nonce holds the final group.
- Warm-up: a counter suppresses all compares for the first PIPE_LATENCY cycles after entering HASH. No invalid results are ever reported.
- Result tracking: a second counter res_base starts at 0 when warm-up ends. It advances by NUM_CORES per compared cycle, so core_hash2[k] in that cycle belongs to nonce res_base + k.
- Compares are active in HASH (after warm-up) and DRAIN, and disabled in IDLE and DONE.
- Match of core k in cycle m:
  - Sets pending[k] and latches its nonce at edge m+1.
  - A fixed-priority arbiter (lowest k first) pushes one pending nonce per cycle into the FIFO.
  - With no contention and a non-full FIFO, golden_valid is high in cycle m+2.
- Simultaneous hits: queued in index order, one per cycle.
- A new match on core k while pending[k] is still set drops the new nonce and sets overflow.
- FIFO full at push: the push is discarded and overflow is set. Push and pop in the same cycle on a full FIFO both succeed.
- FIFO is first-word-fall-through: golden_nonce is valid whenever golden_valid is high. Pop on an empty FIFO is ignored.
- overflow clears only on reset or new_work.

Optional Feature:
- Macro DIFFICULTY_MASK_EN.
- Defined: adds input port diff_mask (32). Match condition is ((core_hash2[k] ^ GOLDEN_WORD) & diff_mask) == 0, which allows lower-difficulty shares. diff_mask is sampled each compare cycle; all-ones equals the undefined behaviour.
- Undefined: the port is absent and match is full 32-bit equality with GOLDEN_WORD.

Test Plan:
Bench setup for all scenarios: NUM_CORES=4, PIPE_LATENCY=10, delay-line hasher model returning GOLDEN_WORD only for nonce 0x00000107.
- Reset, then new_work -> core_nonce = {3,2,1,0} on first HASH cycle, then {7,6,5,4}. golden_nonce=0x107 valid exactly once, 2 cycles after the model's match, busy=1.
- Model returns GOLDEN_WORD for all nonces during the first 10 cycles after new_work -> no FIFO push and golden_valid stays 0.
- Model matches nonces 0x100..0x103 in the same cycle, golden_ready=1 -> FIFO outputs 0x100, 0x101, 0x102, 0x103 on consecutive cycles, overflow=0.
- golden_ready=0 and 9 single matches -> 8 entries held, overflow=1. Then new_work -> overflow=0 and all 8 entries still readable in order.
- Force base to 0xFFFFFFF8 -> core_nonce ends at {FFFFFFFF..FFFFFFFC}, DRAIN lasts 11 cycles, then exhausted=1, busy=0, and a match at nonce 0xFFFFFFFE is reported.
- With DIFFICULTY_MASK_EN, diff_mask=0xFFFF0000 and hash2=0xA41F0000 at nonce 0x55 -> golden_nonce=0x55 is reported. With the macro undefined, the same stimulus reports nothing.

Source files
------------

// File: rtl/multicore_nonce_ctrl.sv
// rtl/multicore_nonce_ctrl.sv - nonce distribution, golden-hash check and result FIFO for NUM_CORES hashers
// Optional feature macro DIFFICULTY_MASK_EN: adds diff_mask so lower-difficulty shares also match.
module multicore_nonce_ctrl #(
  parameter int          NUM_CORES    = 4,
  parameter int          PIPE_LATENCY = 253,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] GOLDEN_WORD  = 32'hA41F32E7
) (
  input  logic                    hash_clk,
  input  logic                    reset,
  input  logic                    new_work,
  input  logic [255:0]            midstate_in,
  input  logic [95:0]             data_in,
  output logic [255:0]            midstate_out,
  output logic [95:0]             data_out,
  output logic [32*NUM_CORES-1:0] core_nonce,
  input  logic [32*NUM_CORES-1:0] core_hash2,
`ifdef DIFFICULTY_MASK_EN
  input  logic [31:0]             diff_mask,
`endif
  output logic                    golden_valid,
  output logic [31:0]             golden_nonce,
  input  logic                    golden_ready,
  output logic                    busy,
  output logic                    exhausted,
  output logic                    overflow
);
  localparam int              WW         = $clog2(PIPE_LATENCY + 1);
  localparam int              FW         = $clog2(FIFO_DEPTH);
  localparam int              IW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [31:0]     STEP       = 32'(NUM_CORES);
  localparam logic [31:0]     FINAL_BASE = 32'd0 - STEP;
  localparam logic [WW-1:0]   LAT        = WW'(PIPE_LATENCY);
  localparam logic [FW:0]     DEPTH      = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HASH, DRAIN, DONE} state_t;

  state_t               state, state_next;
  logic [31:0]          base, res_base;
  logic [WW-1:0]        warm_cnt, drain_cnt;
  logic [NUM_CORES-1:0] pending, match, hit;
  logic [31:0]          pend_nonce [NUM_CORES];
  logic                 compare_en;
  logic                 sel_valid;
  logic [IW-1:0]        sel_idx;
  logic                 push, pop, full, push_ok, drop;
  logic [31:0]          mem [FIFO_DEPTH];
  logic [FW-1:0]        wr_ptr, rd_ptr;
  logic [FW:0]          count;

  always_ff @(posedge hash_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    exhausted  = 1'b0;
    case (state)
      IDLE: ;
      HASH: begin
        busy = 1'b1;
        if (base == FINAL_BASE) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == LAT) state_next = DONE;
      end
      DONE: exhausted = 1'b1;
      default: state_next = IDLE;
    endcase
    if (new_work) state_next = HASH;
  end

  // The last DRAIN cycle would see the held final group a second time, so it is not compared.
  assign compare_en = (state == HASH && warm_cnt == LAT) || (state == DRAIN && drain_cnt != LAT);

  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
`ifdef DIFFICULTY_MASK_EN
      match[k] = ((core_hash2[32*k +: 32] ^ GOLDEN_WORD) & diff_mask) == 32'd0;
`else
      match[k] = core_hash2[32*k +: 32] == GOLDEN_WORD;
`endif
    end
  end

  assign hit = match & {NUM_CORES{compare_en}};

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      midstate_out <= '0;
      data_out     <= '0;
      base         <= '0;
      core_nonce   <= '0;
    end else if (new_work) begin
      midstate_out <= midstate_in;
      data_out     <= data_in;
      base         <= '0;
      for (int k = 0; k < NUM_CORES; k++) core_nonce[32*k +: 32] <= 32'(k);
    end else if (state == HASH && base != FINAL_BASE) begin
      base <= base + STEP;
      for (int k = 0; k < NUM_CORES; k++) core_nonce[32*k +: 32] <= base + STEP + 32'(k);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset || new_work) begin
      warm_cnt  <= '0;
      drain_cnt <= '0;
      res_base  <= '0;
    end else begin
      if (state == HASH && warm_cnt != LAT) warm_cnt <= warm_cnt + WW'(1);
      if (state == DRAIN) drain_cnt <= drain_cnt + WW'(1);
      else                drain_cnt <= '0;
      if (compare_en) res_base <= res_base + STEP;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (pending[k]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(k);
      end
    end
  end

  assign push         = sel_valid & ~new_work;
  assign pop          = golden_valid & golden_ready;
  assign full         = (count == DEPTH);
  assign push_ok      = push & (~full | pop);
  assign drop         = (|(hit & pending)) | (push & full & ~pop);
  assign golden_valid = (count != '0);
  assign golden_nonce = golden_valid ? mem[rd_ptr] : 32'd0;

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < NUM_CORES; k++) pend_nonce[k] <= '0;
    end else if (new_work) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (hit[k] && !pending[k]) begin
          pending[k]    <= 1'b1;
          pend_nonce[k] <= res_base + 32'(k);
        end else if (sel_valid && sel_idx == IW'(k)) begin
          pending[k] <= 1'b0;
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= pend_nonce[sel_idx];
        wr_ptr      <= wr_ptr + FW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FW'(1);
      if (push_ok && !pop)      count <= count + (FW+1)'(1);
      else if (pop && !push_ok) count <= count - (FW+1)'(1);
    end
  end
endmodule

// File: tb/tb_multicore_nonce_ctrl.sv
// tb/tb_multicore_nonce_ctrl.sv - directed bench with a delay-line hasher model
// Optional feature macro DIFFICULTY_MASK_EN selects the masked-match expectation.
module tb_multicore_nonce_ctrl;
  localparam int          NC   = 4;
  localparam int          LAT  = 10;
  localparam logic [31:0] GOLD = 32'hA41F32E7;

  logic           clk;
  logic           reset;
  logic           new_work;
  logic [255:0]   midstate_in, midstate_out;
  logic [95:0]    data_in, data_out;
  logic [127:0]   core_nonce, core_hash2;
  logic           golden_valid, golden_ready;
  logic [31:0]    golden_nonce;
  logic           busy, exhausted, overflow;
`ifdef DIFFICULTY_MASK_EN
  logic [31:0]    diff_mask;
`endif

  logic [31:0]    lo, hi, smask, near;
  logic           all_gold;
  logic [127:0]   pipe [LAT];
  logic [31:0]    pop_q [$];
  int             pop_t [$];
  int             cyc = 0;
  int             ce = 0;
  int             qb = 0;
  int             vcnt = 0;
  int             vb = 0;
  int             n_tests = 0;
  int             n_fail = 0;
  int             n;

  multicore_nonce_ctrl #(
    .NUM_CORES(NC), .PIPE_LATENCY(LAT), .FIFO_DEPTH(8), .GOLDEN_WORD(GOLD)
  ) dut (
    .hash_clk(clk), .reset(reset), .new_work(new_work),
    .midstate_in(midstate_in), .data_in(data_in),
    .midstate_out(midstate_out), .data_out(data_out),
    .core_nonce(core_nonce), .core_hash2(core_hash2),
`ifdef DIFFICULTY_MASK_EN
    .diff_mask(diff_mask),
`endif
    .golden_valid(golden_valid), .golden_nonce(golden_nonce), .golden_ready(golden_ready),
    .busy(busy), .exhausted(exhausted), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= core_nonce;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  function automatic logic [31:0] model_hash(input logic [31:0] nn, input logic [31:0] l, input logic [31:0] h,
                                             input logic [31:0] sm, input logic [31:0] nr, input logic ag);
    if (ag) return GOLD;
    if (nn >= l && nn <= h && (nn & sm) == 32'd0) return GOLD;
    if (nn == nr) return 32'hA41F0000;
    return 32'h0;
  endfunction

  for (genvar k = 0; k < NC; k++) begin : g_model
    assign core_hash2[32*k +: 32] = model_hash(pipe[LAT-1][32*k +: 32], lo, hi, smask, near, all_gold);
  end

  always @(negedge clk) begin
    if (golden_valid) vcnt <= vcnt + 1;
    if (golden_valid && golden_ready) begin
      pop_q.push_back(golden_nonce);
      pop_t.push_back(cyc - ce);
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_work();
    new_work = 1'b1;
    tick();
    new_work = 1'b0;
    ce = cyc;
    qb = pop_q.size();
    vb = vcnt;
  endtask

  task automatic run_to(input int idx);
    while (cyc - ce < idx) tick();
  endtask

  task automatic check_pops(input string tag, input int cnt, input logic [31:0] first,
                            input logic [31:0] stride, input int t0);
    logic [31:0] g;
    int          t;
    check_eq({tag, "_count"}, 256'(pop_q.size() - qb), 256'(cnt));
    for (int i = 0; i < cnt; i++) begin
      g = (qb + i < pop_q.size()) ? pop_q[qb+i] : 32'hxxxxxxxx;
      check_eq($sformatf("%s_nonce%0d", tag, i), 256'(g), 256'(first + stride * 32'(i)));
      if (t0 >= 0) begin
        t = (qb + i < pop_t.size()) ? pop_t[qb+i] : -1;
        check_eq($sformatf("%s_cycle%0d", tag, i), 256'(t), 256'(t0 + i));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; new_work = 1'b0; midstate_in = '0; data_in = '0; golden_ready = 1'b0;
    lo = 32'd1; hi = 32'd0; smask = 32'd0; near = 32'h12345678; all_gold = 1'b0;
`ifdef DIFFICULTY_MASK_EN
    diff_mask = 32'hFFFFFFFF;
`endif
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    check_eq("rst_core_nonce", 256'(core_nonce), 256'(0));
    check_eq("rst_midstate", midstate_out, 256'(0));
    check_eq("rst_data", 256'(data_out), 256'(0));
    check_eq("rst_valid", 256'(golden_valid), 256'(0));
    check_eq("rst_nonce", 256'(golden_nonce), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_exhausted", 256'(exhausted), 256'(0));
    check_eq("rst_overflow", 256'(overflow), 256'(0));

    // single golden nonce 0x107
    lo = 32'h107; hi = 32'h107; golden_ready = 1'b1;
    midstate_in = {8{32'h89ABCDEF}};
    data_in = {3{32'h13579BDF}};
    start_work();
    check_eq("t1_group0", 256'(core_nonce), 256'({32'd3, 32'd2, 32'd1, 32'd0}));
    check_eq("t1_midstate", midstate_out, {8{32'h89ABCDEF}});
    check_eq("t1_data", 256'(data_out), 256'({3{32'h13579BDF}}));
    check_eq("t1_busy", 256'(busy), 256'(1));
    midstate_in = '0; data_in = '0;
    tick();
    check_eq("t1_group1", 256'(core_nonce), 256'({32'd7, 32'd6, 32'd5, 32'd4}));
    check_eq("t1_midstate_hold", midstate_out, {8{32'h89ABCDEF}});
    run_to(100);
    check_pops("t1", 1, 32'h107, 32'd0, 77);
    check_eq("t1_overflow", 256'(overflow), 256'(0));

    // golden everywhere during warm-up
    lo = 32'd1; hi = 32'd0; all_gold = 1'b1;
    start_work();
    repeat (LAT) tick();
    all_gold = 1'b0;
    run_to(40);
    check_eq("t2_valid_cycles", 256'(vcnt - vb), 256'(0));
    check_pops("t2", 0, 32'd0, 32'd0, -1);

    // four simultaneous hits
    lo = 32'h100; hi = 32'h103;
    start_work();
    run_to(90);
    check_pops("t3", 4, 32'h100, 32'd1, 76);
    check_eq("t3_overflow", 256'(overflow), 256'(0));

    // nine single hits with no reader
    lo = 32'h200; hi = 32'h280; smask = 32'hF; golden_ready = 1'b0;
    start_work();
    run_to(185);
    check_eq("t4_overflow_set", 256'(overflow), 256'(1));
    check_eq("t4_valid", 256'(golden_valid), 256'(1));
    check_eq("t4_head", 256'(golden_nonce), 256'(32'h200));
    lo = 32'd1; hi = 32'd0; smask = 32'd0;
    start_work();
    check_eq("t4_overflow_clr", 256'(overflow), 256'(0));
    check_eq("t4_head_kept", 256'(golden_nonce), 256'(32'h200));
    golden_ready = 1'b1;
    repeat (10) tick();
    golden_ready = 1'b0;
    check_pops("t4", 8, 32'h200, 32'h10, 0);
    check_eq("t4_empty", 256'(golden_valid), 256'(0));

    // nonce-space exhaustion
    lo = 32'hFFFFFFFE; hi = 32'hFFFFFFFE; golden_ready = 1'b1;
    start_work();
    run_to(20);
    force dut.base = 32'hFFFFFFF8;
    force dut.res_base = 32'hFFFFFFD0;
    #1;
    release dut.base;
    release dut.res_base;
    tick();
    check_eq("t5_final_group", 256'(core_nonce), 256'({32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC}));
    check_eq("t5_busy_hash", 256'(busy), 256'(1));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
      n++;
    end
    check_eq("t5_drain_cycles", 256'(n), 256'(11));
    check_eq("t5_exhausted", 256'(exhausted), 256'(1));
    check_eq("t5_busy_done", 256'(busy), 256'(0));
    check_eq("t5_group_held", 256'(core_nonce), 256'({32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC}));
    repeat (5) tick();
    check_pops("t5", 1, 32'hFFFFFFFE, 32'd0, 33);

    // near-golden hash at nonce 0x55
    lo = 32'd1; hi = 32'd0; near = 32'h55;
`ifdef DIFFICULTY_MASK_EN
    diff_mask = 32'hFFFF0000;
`endif
    start_work();
    run_to(50);
`ifdef DIFFICULTY_MASK_EN
    check_pops("t6", 1, 32'h55, 32'd0, 33);
`else
    check_pops("t6", 0, 32'd0, 32'd0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
